// File: rtl/lock_pkg.sv
// Shared definitions for the code-entry path: digit/code geometry,
// checker FSM states and the length clamp used wherever a length is consumed.
package lock_pkg;
  localparam int DIGIT_W    = 4;
  localparam int MAX_DIGITS = 6;
  localparam int CODE_W     = 24;
  localparam int LEN_W      = 3;

  typedef enum logic [2:0] {IDLE, LEN, CMP, DONE, LOCK} state_t;

  // Lengths above MAX_DIGITS (only 7 fits in LEN_W) mean a full code.
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
    return (len > LEN_W'(MAX_DIGITS)) ? LEN_W'(MAX_DIGITS) : len;
  endfunction
endpackage

// File: rtl/code_checker_lockout_timer.sv
// Down-counter for the lockout window: load sets it to CYCLES, it counts to 0,
// and expire flags the last counted cycle (count == 1).
module lockout_timer #(
  parameter int CYCLES = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic expire
);
  localparam int W = $clog2(CYCLES + 1);

  logic [W-1:0] count;

  // Load wins over counting; idle at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              count <= '0;
    else if (load)        count <= W'(CYCLES);
    else if (count != '0) count <= count - W'(1);
  end

  assign expire = (count == W'(1));
endmodule

// File: rtl/code_checker.sv
// Passcode store and digit-serial checker with consecutive-failure lockout.
// Build option: CODE_CHECKER_EARLY_EXIT_EN ends the digit walk at the first
// mismatching digit; undefined keeps a constant-time full walk.
module code_checker
  import lock_pkg::*;
#(
  parameter int MAX_FAILS      = 3,
  parameter int LOCKOUT_CYCLES = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              save,
  input  logic              check,
  input  logic [CODE_W-1:0] newcode,
  input  logic [LEN_W-1:0]  length,
  output logic              stored_valid,
  output logic              busy,
  output logic              done,
  output logic              match,
  output logic              locked,
  output logic [2:0]        fail_count
);
  state_t             state, state_n;
  logic [CODE_W-1:0]  stored_code, snap_code;
  logic [LEN_W-1:0]   stored_len, snap_len;
  logic [LEN_W-1:0]   idx;
  logic               acc;
  logic               digit_eq;
  logic [2:0]         fail_next;
  logic               timer_load;
  logic               expire;

  assign digit_eq  = (snap_code[idx*DIGIT_W +: DIGIT_W] == stored_code[idx*DIGIT_W +: DIGIT_W]);
  assign fail_next = fail_count + 3'd1;

  lockout_timer #(.CYCLES(LOCKOUT_CYCLES)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (timer_load),
    .expire (expire)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state logic; lockout timer is loaded on the failing DONE that hits the limit.
  always_comb begin
    state_n    = state;
    timer_load = 1'b0;
    case (state)
      IDLE: if (check && !save) state_n = LEN;
      LEN:  if (snap_len != stored_len || snap_len == '0) state_n = DONE;
            else                                          state_n = CMP;
`ifdef CODE_CHECKER_EARLY_EXIT_EN
      CMP:  if (idx == '0 || !digit_eq) state_n = DONE;
`else
      CMP:  if (idx == '0) state_n = DONE;
`endif
      DONE: if (!acc && fail_next == 3'(MAX_FAILS)) begin
              state_n    = LOCK;
              timer_load = 1'b1;
            end else begin
              state_n = IDLE;
            end
      LOCK: if (expire) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Datapath and registered outputs; done is a single-cycle pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stored_code  <= '0;
      stored_len   <= '0;
      stored_valid <= 1'b0;
      snap_code    <= '0;
      snap_len     <= '0;
      idx          <= '0;
      acc          <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      match        <= 1'b0;
      locked       <= 1'b0;
      fail_count   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (save) begin
            stored_code  <= newcode;
            stored_len   <= clamp_len(length);
            stored_valid <= 1'b1;
          end else if (check) begin
            snap_code <= newcode;
            snap_len  <= clamp_len(length);
            busy      <= 1'b1;
          end
        end
        LEN: begin
          // Without a stored code nothing can match, even a zero-length entry.
          acc <= stored_valid && (snap_len == stored_len);
          idx <= snap_len - LEN_W'(1);
        end
        CMP: begin
          acc <= acc && digit_eq;
          idx <= idx - LEN_W'(1);
        end
        DONE: begin
          done  <= 1'b1;
          match <= acc;
          busy  <= 1'b0;
          if (acc) fail_count <= '0;
          else     fail_count <= fail_next;
          if (timer_load) locked <= 1'b1;
        end
        LOCK: begin
          if (expire) begin
            locked     <= 1'b0;
            fail_count <= '0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_code_checker.sv
// Vector-table bench for code_checker with a scoreboard queue of expected
// results plus hand-written lockout, save/check collision and reset sequences.
module tb_code_checker;
  localparam int MAXF  = 3;
  localparam int LOCKC = 10;
`ifdef CODE_CHECKER_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        save;
  logic        check;
  logic [23:0] newcode;
  logic [2:0]  length;
  logic        stored_valid, busy, done, match, locked;
  logic [2:0]  fail_count;

  always #5 clk = ~clk;

  code_checker #(.MAX_FAILS(MAXF), .LOCKOUT_CYCLES(LOCKC)) dut (
    .clk          (clk),
    .rst          (rst),
    .save         (save),
    .check        (check),
    .newcode      (newcode),
    .length       (length),
    .stored_valid (stored_valid),
    .busy         (busy),
    .done         (done),
    .match        (match),
    .locked       (locked),
    .fail_count   (fail_count)
  );

  typedef struct {
    bit          do_save;
    logic [23:0] scode;
    logic [2:0]  slen;
    logic [23:0] ccode;
    logic [2:0]  clen;
    bit          exp_match;
    int          lat_full;
    int          lat_early;
    logic [2:0]  exp_fc;
  } vec_t;

  typedef struct {
    bit         m;
    int         lat;
    logic [2:0] fc;
  } exp_t;

  exp_t sb[$];
  vec_t vt[12];
  int   applied     = 0;
  int   miscompares = 0;

  function automatic vec_t mk(bit ds, logic [23:0] sc, logic [2:0] sl, logic [23:0] cc,
                              logic [2:0] cl, bit em, int lf, int le, logic [2:0] fc);
    vec_t v;
    v.do_save = ds; v.scode = sc; v.slen = sl; v.ccode = cc; v.clen = cl;
    v.exp_match = em; v.lat_full = lf; v.lat_early = le; v.exp_fc = fc;
    return v;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_save(input logic [23:0] c, input logic [2:0] l);
    @(negedge clk);
    save = 1'b1; newcode = c; length = l;
    @(posedge clk); #1;
    save = 1'b0; newcode = 24'($urandom); length = 3'($urandom);
  endtask

  task automatic expect_no_done(input string name, input int n);
    int cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (done) cnt++;
    end
    cmp(name, cnt, 0);
  endtask

  // Drive one check, push its expectation, then wait (bounded) for done and score it.
  task automatic run_check(input string name, input logic [23:0] c, input logic [2:0] l,
                           input bit em, input int lat, input logic [2:0] efc);
    exp_t e;
    bit   got = 1'b0;
    int   k;
    @(negedge clk);
    check = 1'b1; newcode = c; length = l;
    e.m = em; e.lat = lat; e.fc = efc;
    sb.push_back(e);
    @(posedge clk); #1;
    check = 1'b0; newcode = 24'($urandom); length = 3'($urandom);
    cmp({name, " busy_hi"}, busy, 1);
    for (k = 1; k <= 40; k++) begin
      if (k > 1) begin @(posedge clk); #1; end
      if (k == 1) begin @(posedge clk); #1; end
      if (done) begin got = 1'b1; break; end
    end
    e = sb.pop_front();
    if (!got) begin
      applied++; miscompares++;
      $display("FAIL %s timeout: no done within 40 cycles, expected latency %0d", name, e.lat);
    end else begin
      cmp({name, " latency"}, k, e.lat);
      cmp({name, " match"}, match, e.m);
      cmp({name, " fail_count"}, fail_count, e.fc);
      cmp({name, " busy_lo"}, busy, 0);
    end
  endtask

  initial begin
    int k;
    int dones;
    vt[0]  = mk(1, 24'h000123, 3'd3, 24'h000123, 3'd3, 1, 5, 5, 3'd0);
    vt[1]  = mk(0, 24'h0,      3'd0, 24'h000124, 3'd3, 0, 5, 5, 3'd1);
    vt[2]  = mk(0, 24'h0,      3'd0, 24'h001234, 3'd4, 0, 2, 2, 3'd2);
    vt[3]  = mk(0, 24'h0,      3'd0, 24'h000123, 3'd3, 1, 5, 5, 3'd0);
    vt[4]  = mk(0, 24'h0,      3'd0, 24'h000923, 3'd3, 0, 5, 3, 3'd1);
    vt[5]  = mk(0, 24'h0,      3'd0, 24'h000000, 3'd0, 0, 2, 2, 3'd2);
    vt[6]  = mk(1, 24'hABCDEF, 3'd7, 24'hABCDEF, 3'd6, 1, 8, 8, 3'd0);
    vt[7]  = mk(0, 24'h0,      3'd0, 24'hABCDE0, 3'd7, 0, 8, 8, 3'd1);
    vt[8]  = mk(0, 24'h0,      3'd0, 24'h1BCDEF, 3'd6, 0, 8, 3, 3'd2);
    vt[9]  = mk(0, 24'h0,      3'd0, 24'hABCDEF, 3'd7, 1, 8, 8, 3'd0);
    vt[10] = mk(1, 24'h000000, 3'd0, 24'h000000, 3'd0, 1, 2, 2, 3'd0);
    vt[11] = mk(0, 24'h0,      3'd0, 24'h000001, 3'd0, 1, 2, 2, 3'd0);

    rst = 1'b1; save = 1'b0; check = 1'b0; newcode = '0; length = '0;
    #12;
    cmp("reset outputs", {stored_valid, busy, done, match, locked, fail_count}, 0);
    @(negedge clk); rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      if (vt[i].do_save) begin
        do_save(vt[i].scode, vt[i].slen);
        cmp($sformatf("vec%0d stored_valid", i), stored_valid, 1);
      end
      run_check($sformatf("vec%0d", i), vt[i].ccode, vt[i].clen, vt[i].exp_match,
                EARLY ? vt[i].lat_early : vt[i].lat_full, vt[i].exp_fc);
    end

    // Lockout: three failures, requests ignored while locked, window of LOCKC cycles.
    do_save(24'h000123, 3'd3);
    run_check("lk_f1", 24'h001234, 3'd4, 0, 2, 3'd1);
    run_check("lk_f2", 24'h001234, 3'd4, 0, 2, 3'd2);
    run_check("lk_f3", 24'h001234, 3'd4, 0, 2, 3'd3);
    cmp("lk locked", locked, 1);
    dones = 0;
    for (k = 1; k <= 30; k++) begin
      @(negedge clk);
      check = (k == 2); save = (k == 4);
      newcode = (k == 4) ? 24'h000999 : 24'h000123; length = 3'd3;
      @(posedge clk); #1;
      if (done) dones++;
      if (!locked) break;
    end
    check = 1'b0; save = 1'b0;
    cmp("lk duration", k, LOCKC);
    cmp("lk done during lock", dones, 0);
    cmp("lk fail_count cleared", fail_count, 0);
    run_check("lk after", 24'h000123, 3'd3, 1, 5, 3'd0);

    // Save and check together: save wins, no done.
    @(negedge clk);
    save = 1'b1; check = 1'b1; newcode = 24'h000456; length = 3'd3;
    @(posedge clk); #1;
    save = 1'b0; check = 1'b0;
    expect_no_done("sc no done", 8);
    run_check("sc new code", 24'h000456, 3'd3, 1, 5, 3'd0);

    // Reset in the middle of a comparison.
    @(negedge clk);
    check = 1'b1; newcode = 24'h000456; length = 3'd3;
    @(posedge clk); #1; check = 1'b0;
    @(posedge clk); @(posedge clk); #2;
    rst = 1'b1; #1;
    cmp("rst busy", busy, 0);
    cmp("rst stored_valid", stored_valid, 0);
    cmp("rst done", done, 0);
    @(negedge clk); rst = 1'b0;
    expect_no_done("rst no done", 6);
    run_check("rst recheck", 24'h000456, 3'd3, 0, 2, 3'd1);
    run_check("rst zero len", 24'h000000, 3'd0, 0, 2, 3'd2);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end
endmodule
